round_divider_pipe: RTL and testbench



---
 rtl/round_divider_pipe.sv | 147 ++++++++++++++
 tb/tb_round_divider_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_divider_pipe.sv
// Fully pipelined unsigned restoring divider with per-operation round-half-up.
// A single global stall holds every rank whenever the output is not accepted.
module round_divider_pipe #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_round,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic             out_rounded,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N = WIDTH / BITS_PER_STAGE;

    logic stall_s;
    logic round_up_s;

    // Rank 0 captures the operation; ranks 1..N each resolve BITS_PER_STAGE quotient bits.
    // qd holds the unconsumed dividend bits in its top and the quotient bits shifted in below.
    logic [N:0]       vld_q;
    logic [N:0]       rnd_q;
    logic [N:0]       zero_q;
    logic [WIDTH-1:0] rem_q [0:N];
    logic [WIDTH-1:0] qd_q  [0:N];
    logic [WIDTH-1:0] dvs_q [0:N];
    logic [TAG_W-1:0] tag_q [0:N];

    logic [WIDTH-1:0] rem_d [1:N];
    logic [WIDTH-1:0] qd_d  [1:N];
    logic [WIDTH-1:0] q_round_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_quotient_q;
    logic [WIDTH-1:0] out_remainder_q;
    logic             out_div_zero_q;
    logic             out_rounded_q;
    logic [TAG_W-1:0] out_tag_q;

    assign stall_s  = out_valid_q && !out_ready;
    assign in_ready = !stall_s;

    // Restoring iterations for every division stage, MSB first.
    always_comb begin
        logic [WIDTH:0]   r_v;
        logic [WIDTH-1:0] qd_v;
        r_v  = '0;
        qd_v = '0;
        for (int s = 1; s <= N; s++) begin
            r_v  = {1'b0, rem_q[s-1]};
            qd_v = qd_q[s-1];
            for (int b = 0; b < BITS_PER_STAGE; b++) begin
                r_v  = {r_v[WIDTH-1:0], qd_v[WIDTH-1]};
                qd_v = {qd_v[WIDTH-2:0], 1'b0};
                if (r_v >= {1'b0, dvs_q[s-1]}) begin
                    r_v     = r_v - {1'b0, dvs_q[s-1]};
                    qd_v[0] = 1'b1;
                end else begin
                    qd_v[0] = 1'b0;
                end
            end
            rem_d[s] = r_v[WIDTH-1:0];
            qd_d[s]  = qd_v;
        end
    end

    // Round half-up: remainder < divisor, so doubling it fits in WIDTH+1 bits.
    always_comb begin
        round_up_s = rnd_q[N] && !zero_q[N] &&
                     ({rem_q[N], 1'b0} >= {1'b0, dvs_q[N]});
        if (round_up_s) begin
            q_round_d = qd_q[N] + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q_round_d = qd_q[N];
        end
    end

    // Pipeline ranks; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            rnd_q  <= '0;
            zero_q <= '0;
            for (int s = 0; s <= N; s++) begin
                rem_q[s] <= '0;
                qd_q[s]  <= '0;
                dvs_q[s] <= '0;
                tag_q[s] <= '0;
            end
        end else if (!stall_s) begin
            vld_q[0]  <= in_valid;
            rnd_q[0]  <= in_round;
            zero_q[0] <= (in_divisor == {WIDTH{1'b0}});
            rem_q[0]  <= '0;
            qd_q[0]   <= in_dividend;
            dvs_q[0]  <= in_divisor;
            tag_q[0]  <= in_tag;
            for (int s = 1; s <= N; s++) begin
                vld_q[s]  <= vld_q[s-1];
                rnd_q[s]  <= rnd_q[s-1];
                zero_q[s] <= zero_q[s-1];
                rem_q[s]  <= rem_d[s];
                qd_q[s]   <= qd_d[s];
                dvs_q[s]  <= dvs_q[s-1];
                tag_q[s]  <= tag_q[s-1];
            end
        end
    end

    // Output register rank, frozen while the consumer withholds out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_div_zero_q  <= 1'b0;
            out_rounded_q   <= 1'b0;
            out_tag_q       <= '0;
        end else if (!stall_s) begin
            out_valid_q     <= vld_q[N];
            out_quotient_q  <= q_round_d;
            out_remainder_q <= rem_q[N];
            out_div_zero_q  <= zero_q[N];
            out_rounded_q   <= round_up_s;
            out_tag_q       <= tag_q[N];
        end
    end

    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_div_zero  = out_div_zero_q;
    assign out_rounded   = out_rounded_q;
    assign out_tag       = out_tag_q;

endmodule

// File: tb/tb_round_divider_pipe.sv
// Randomised and directed bench for round_divider_pipe; results come from a
// slot-by-slot occupancy model holding arithmetic reference results.
module tb_round_divider_pipe;

    localparam int L = 10;  // input rank + 8 division stages + output rank

    typedef struct packed {
        logic        v;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        rnd;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic        in_round;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_div_zero;
    logic        out_rounded;
    logic [3:0]  out_tag;

    int n_vec = 0;
    int n_err = 0;

    exp_t pipe_m [0:L-1];

    round_divider_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .in_round(in_round), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div_zero(out_div_zero), .out_rounded(out_rounded),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] d,
                                     input logic rnd, input logic [3:0] t);
        exp_t e;
        longint unsigned ua, ud, uq, ur;
        e.v = 1'b1;
        e.tag = t;
        if (d == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.rnd = 1'b0;
        end else begin
            ua = 64'(a); ud = 64'(d);
            uq = ua / ud; ur = ua % ud;
            e.dz = 1'b0; e.rnd = 1'b0;
            if (rnd && (2 * ur >= ud)) begin
                uq = uq + 1;
                e.rnd = 1'b1;
            end
            e.q = uq[31:0]; e.r = ur[31:0];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Occupancy model: the whole pipe advances as one shift register unless the output is held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) pipe_m[i] <= '0;
        end else if (!(pipe_m[L-1].v && !out_ready)) begin
            for (int i = L-1; i > 0; i--) pipe_m[i] <= pipe_m[i-1];
            if (in_valid) pipe_m[0] <= ref_div(in_dividend, in_divisor, in_round, in_tag);
            else          pipe_m[0] <= '0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("in_ready", in_ready, !(pipe_m[L-1].v && !out_ready));
            chk("out_valid", out_valid, pipe_m[L-1].v);
            if (pipe_m[L-1].v) begin
                chk("quotient", out_quotient, pipe_m[L-1].q);
                chk("remainder", out_remainder, pipe_m[L-1].r);
                chk("div_zero", out_div_zero, pipe_m[L-1].dz);
                chk("rounded", out_rounded, pipe_m[L-1].rnd);
                chk("tag", out_tag, pipe_m[L-1].tag);
            end
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic r, input logic [3:0] t);
        @(negedge clk); #1;
        in_valid = 1'b1; in_dividend = a; in_divisor = d; in_round = r; in_tag = t;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic rand_op();
        logic [31:0] a, d;
        case ($urandom_range(0, 3))
            0:       d = 32'd0;
            1:       d = 32'($urandom_range(1, 15));
            2:       d = $urandom;
            default: d = $urandom >> $urandom_range(0, 31);
        endcase
        a = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
        op(a, d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    // Waits from the accept edge of the op just driven until its result shows.
    task automatic wait_result(output int cnt);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int lat;
        logic [31:0] frz_q, frz_r;
        logic [3:0]  frz_t;

        rst = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
        in_round = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_quotient", out_quotient, 0);
        chk("rst_remainder", out_remainder, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_flags", {out_div_zero, out_rounded}, 0);
        #1 rst = 1'b0;

        e = ref_div(32'd100, 32'd8, 1'b0, 4'd0);
        chk("pin_100_8_trunc", {e.q, e.r}, {32'd12, 32'd4});
        e = ref_div(32'd100, 32'd8, 1'b1, 4'd0);
        chk("pin_100_8_round", {e.q, e.r, 31'd0, e.rnd}, {32'd13, 32'd4, 31'd0, 1'b1});
        e = ref_div(32'd100, 32'd7, 1'b1, 4'd0);
        chk("pin_100_7_round", {e.q, e.r, 31'd0, e.rnd}, {32'd14, 32'd2, 31'd0, 1'b0});
        e = ref_div(32'hFFFF_FFFF, 32'd2, 1'b1, 4'd0);
        chk("pin_max_2", {e.q, e.r}, {32'h8000_0000, 32'd1});
        e = ref_div(32'd55, 32'd0, 1'b1, 4'd9);
        chk("pin_div0", {e.q, e.r, 28'd0, e.tag}, {32'hFFFF_FFFF, 32'd55, 28'd0, 4'd9});

        op(32'd100, 32'd8, 1'b0, 4'd1);
        op(32'd100, 32'd8, 1'b1, 4'd2);
        op(32'd100, 32'd7, 1'b1, 4'd3);
        op(32'hFFFF_FFFF, 32'd1, 1'b1, 4'd4);
        op(32'hFFFF_FFFF, 32'd2, 1'b1, 4'd5);
        op(32'd0, 32'd5, 1'b0, 4'd6);
        op(32'd55, 32'd0, 1'b1, 4'd7);
        idle(14);

        fork
            for (int i = 0; i < 20; i++) rand_op();
            begin
                wait (in_valid === 1'b1);
                @(posedge clk);
                lat = 0;
                while (lat < 50) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) break;
                    lat++;
                end
                chk("stream_latency", lat, 9);
            end
        join

        for (int i = 0; i < 12; i++) rand_op();
        @(negedge clk); #1;
        out_ready = 1'b0;
        frz_q = out_quotient; frz_r = out_remainder; frz_t = out_tag;
        chk("bp_full", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_dividend = $urandom; in_divisor = 32'($urandom_range(1, 99)); in_tag = 4'(i);
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_frozen", {frz_q, frz_r, frz_t}, {out_quotient, out_remainder, out_tag});
            #1;
        end
        out_ready = 1'b1;
        idle(14);

        for (int i = 0; i < 4; i++) rand_op();
        @(negedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        op(32'd9, 32'd2, 1'b1, 4'd11);
        wait_result(lat);
        chk("rst_new_latency", lat, 9);
        chk("rst_new_result", {out_quotient, out_remainder}, {32'd5, 32'd1});
        idle(3);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_dividend = $urandom >> $urandom_range(0, 31);
                in_divisor = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                in_round = 1'($urandom_range(0, 1));
                in_tag = 4'($urandom_range(0, 15));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk); #1;
        out_ready = 1'b1;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
